// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART transmitter.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Fractional bit-rate generator: steps by BAUD each clock, ticks on each wrap at CLK_HZ.
module uart_baud_gen #(
   parameter int CLK_HZ = 68000000,
   parameter int BAUD   = 115200
) (
   input  logic sys_clk_i,
   input  logic sys_rst_i,
   input  logic clr,
   output logic tick
);

   localparam int            AW   = $clog2(CLK_HZ + BAUD) + 1;
   localparam logic [AW-1:0] STEP = AW'(BAUD);
   localparam logic [AW-1:0] WRAP = AW'(CLK_HZ);

   logic [AW-1:0] r_acc;
   logic [AW-1:0] w_sum;

   assign w_sum = r_acc + STEP;
   // Combinational tick so the FSM advances on the very edge the wrap happens.
   assign tick  = (w_sum >= WRAP);

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i)  r_acc <= '0;
      else if (clr)   r_acc <= '0;
      else if (tick)  r_acc <= w_sum - WRAP;
      else            r_acc <= w_sum;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small inline transmit FIFO; frames go out back-to-back while data is queued.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 68000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 sys_clk_i,
   input  logic                 sys_rst_i,
   input  logic                 uart_wr_i,
   input  logic [DATA_BITS-1:0] uart_dat_i,
   output logic                 uart_full,
   output logic                 uart_busy,
   output logic                 uart_tx
);

   localparam int            PW        = $clog2(FIFO_DEPTH) + 1;
   localparam int            CW        = $clog2(DATA_BITS);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]        r_wptr, r_rptr;
   logic [DATA_BITS-1:0] r_shift;
   logic [CW-1:0]        r_bitcnt;
   logic                 r_par, r_tx;
   uart_state_t          r_state;

   logic                 w_empty, w_full, w_push, w_pop, w_tick, w_par_bit;
   logic [DATA_BITS-1:0] w_head;

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
   assign w_head  = r_mem[r_rptr[PW-2:0]];
   // Pop happens exactly on entry to START, which is also when the bit timer restarts.
   assign w_pop   = !w_empty && ((r_state == IDLE) ||
                                 (r_state == STOP && w_tick && r_bitcnt == STOP_LAST));
   assign w_push  = uart_wr_i && (!w_full || w_pop);
   assign w_par_bit = (PARITY == PAR_ODD) ? ~^w_head : ^w_head;

   assign uart_full = w_full;
   assign uart_busy = !((r_state == IDLE) && w_empty);
   assign uart_tx   = r_tx;

   uart_baud_gen #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_baud (
      .sys_clk_i (sys_clk_i),
      .sys_rst_i (sys_rst_i),
      .clr       (w_pop),
      .tick      (w_tick)
   );

   always_ff @(posedge sys_clk_i) begin
      if (w_push) r_mem[r_wptr[PW-2:0]] <= uart_dat_i;
   end

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
      end
   end

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         r_state  <= IDLE;
         r_tx     <= 1'b1;
         r_shift  <= '0;
         r_par    <= 1'b0;
         r_bitcnt <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_pop) begin
               r_state <= START;
               r_tx    <= 1'b0;
               r_shift <= w_head;
               r_par   <= w_par_bit;
            end
            START: if (w_tick) begin
               r_state  <= DATA;
               r_tx     <= r_shift[0];
               r_shift  <= r_shift >> 1;
               r_bitcnt <= '0;
            end
            DATA: if (w_tick) begin
               if (r_bitcnt == DATA_LAST) begin
                  r_bitcnt <= '0;
                  if (PARITY != PAR_NONE) begin
                     r_state <= PAR;
                     r_tx    <= r_par;
                  end else begin
                     r_state <= STOP;
                     r_tx    <= 1'b1;
                  end
               end else begin
                  r_bitcnt <= r_bitcnt + CW'(1);
                  r_tx     <= r_shift[0];
                  r_shift  <= r_shift >> 1;
               end
            end
            PAR: if (w_tick) begin
               r_state  <= STOP;
               r_tx     <= 1'b1;
               r_bitcnt <= '0;
            end
            STOP: if (w_tick) begin
               if (r_bitcnt == STOP_LAST) begin
                  r_bitcnt <= '0;
                  if (w_pop) begin
                     r_state <= START;
                     r_tx    <= 1'b0;
                     r_shift <= w_head;
                     r_par   <= w_par_bit;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_bitcnt <= r_bitcnt + CW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: 8N1, 7E2, FIFO fill/drop, push-on-pop, async reset and default-rate timing.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr0 = 1'b0, wr1 = 1'b0, wr2 = 1'b0;
   logic [7:0] dat0 = '0;
   logic [6:0] dat1 = '0;
   logic [7:0] dat2 = '0;
   logic       full0, busy0, tx0, full1, busy1, tx1, full2, busy2, tx2;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) d0 (
      .sys_clk_i(clk), .sys_rst_i(rst), .uart_wr_i(wr0), .uart_dat_i(dat0),
      .uart_full(full0), .uart_busy(busy0), .uart_tx(tx0));

   uart_tx_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) d1 (
      .sys_clk_i(clk), .sys_rst_i(rst), .uart_wr_i(wr1), .uart_dat_i(dat1),
      .uart_full(full1), .uart_busy(busy1), .uart_tx(tx1));

   uart_tx_fifo d2 (
      .sys_clk_i(clk), .sys_rst_i(rst), .uart_wr_i(wr2), .uart_dat_i(dat2),
      .uart_full(full2), .uart_busy(busy2), .uart_tx(tx2));

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      checks++; if (tx0 !== 1'b1)   begin errors++; $display("FAIL rst_tx0 got %b want 1", tx0); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy0 got %b want 0", busy0); end
      checks++; if (full0 !== 1'b0) begin errors++; $display("FAIL rst_full0 got %b want 0", full0); end
      checks++; if (tx1 !== 1'b1 || tx2 !== 1'b1) begin errors++; $display("FAIL rst_tx12 got %b%b want 11", tx1, tx2); end
      step(); step();
      rst = 1'b0;
      step();
      checks++; if (busy0 !== 1'b0 || tx0 !== 1'b1) begin errors++; $display("FAIL post_rst_idle busy=%b tx=%b want 0/1", busy0, tx0); end
   endtask

   task automatic test_8n1();
      logic [9:0] exp;
      exp = {1'b1, 8'h55, 1'b0};
      dat0 = 8'h55; wr0 = 1'b1;
      step();
      wr0 = 1'b0;
      checks++; if (tx0 !== 1'b1 || busy0 !== 1'b1) begin errors++; $display("FAIL 8n1_queued tx=%b busy=%b want 1/1", tx0, busy0); end
      step();
      for (int t = 0; t <= 100; t++) begin
         if (t == 0) begin
            checks++; if (tx0 !== 1'b0) begin errors++; $display("FAIL 8n1_latency got %b want 0", tx0); end
         end
         if (t % 10 == 5) begin
            checks++; if (tx0 !== exp[t/10]) begin errors++; $display("FAIL 8n1_bit%0d got %b want %b", t/10, tx0, exp[t/10]); end
         end
         if (t == 99) begin
            checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL 8n1_busy99 got %b want 1", busy0); end
         end
         if (t == 100) begin
            checks++; if (busy0 !== 1'b0 || tx0 !== 1'b1) begin errors++; $display("FAIL 8n1_end busy=%b tx=%b want 0/1", busy0, tx0); end
         end
         if (t < 100) step();
      end
   endtask

   task automatic test_7e2_parity();
      logic [10:0] exp;
      exp = {2'b11, 1'b1, 7'h07, 1'b0};
      dat1 = 7'h07; wr1 = 1'b1;
      step();
      wr1 = 1'b0;
      step();
      for (int t = 0; t <= 110; t++) begin
         if (t % 10 == 5) begin
            checks++; if (tx1 !== exp[t/10]) begin errors++; $display("FAIL 7e2_bit%0d got %b want %b", t/10, tx1, exp[t/10]); end
         end
         if (t == 109) begin
            checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL 7e2_busy109 got %b want 1", busy1); end
         end
         if (t == 110) begin
            checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL 7e2_end got %b want 0", busy1); end
         end
         if (t < 110) step();
      end
   endtask

   // 0x01 leaves the FIFO the edge after it is written, so 0x02..0x05 fill it and 0x06 is dropped.
   task automatic test_fifo_full();
      logic [7:0] byt;
      logic       expb;
      int         b, f, p;
      dat0 = 8'h01; wr0 = 1'b1;
      step();
      dat0 = 8'h02;
      step();
      for (int t = 0; t <= 500; t++) begin
         if (t == 2) begin
            checks++; if (full0 !== 1'b0) begin errors++; $display("FAIL fifo_not_full4 got %b want 0", full0); end
         end
         if (t == 3) begin
            checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL fifo_full5 got %b want 1", full0); end
         end
         if (t < 4) dat0 = 8'(t + 3);
         if (t == 4) begin
            wr0 = 1'b0;
            checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL fifo_drop_full got %b want 1", full0); end
         end
         if (t % 10 == 5) begin
            b = t / 10; f = b / 10; p = b % 10;
            byt = 8'(f + 1);
            expb = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : byt[p-1];
            checks++; if (tx0 !== expb) begin errors++; $display("FAIL fifo_frame%0d_bit%0d got %b want %b", f, p, tx0, expb); end
         end
         if (t == 499) begin
            checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL fifo_busy499 got %b want 1", busy0); end
         end
         if (t == 500) begin
            checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL fifo_idle500 got %b want 0", busy0); end
         end
         if (t < 500) step();
      end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] bytes [6];
      logic [7:0] byt;
      logic       expb;
      int         b, f, p;
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'hC5};
      dat0 = bytes[0]; wr0 = 1'b1;
      step();
      dat0 = bytes[1];
      step();
      for (int t = 0; t <= 600; t++) begin
         if (t < 3) dat0 = bytes[t+2];
         if (t == 3) begin
            wr0 = 1'b0;
            checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL pp_full got %b want 1", full0); end
         end
         if (t == 99) begin
            checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL pp_full_prepop got %b want 1", full0); end
            wr0 = 1'b1; dat0 = bytes[5];
         end
         if (t == 100) begin
            wr0 = 1'b0;
            checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL pp_full_after got %b want 1", full0); end
         end
         if (t % 10 == 5) begin
            b = t / 10; f = b / 10; p = b % 10;
            byt = bytes[f];
            expb = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : byt[p-1];
            checks++; if (tx0 !== expb) begin errors++; $display("FAIL pp_frame%0d_bit%0d got %b want %b", f, p, tx0, expb); end
         end
         if (t == 599) begin
            checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL pp_busy599 got %b want 1", busy0); end
         end
         if (t == 600) begin
            checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL pp_idle600 got %b want 0", busy0); end
         end
         if (t < 600) step();
      end
   endtask

   task automatic test_async_reset();
      logic [9:0] exp;
      exp = {1'b1, 8'h3C, 1'b0};
      dat0 = 8'h12; wr0 = 1'b1;
      step();
      dat0 = 8'h34;
      step();
      dat0 = 8'h56;
      step();
      wr0 = 1'b0;
      repeat (34) step();
      checks++; if (tx0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL ar_pre tx=%b busy=%b want 0/1", tx0, busy0); end
      #2 rst = 1'b1;
      #1;
      checks++; if (tx0 !== 1'b1)   begin errors++; $display("FAIL ar_tx got %b want 1", tx0); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL ar_busy got %b want 0", busy0); end
      checks++; if (full0 !== 1'b0) begin errors++; $display("FAIL ar_full got %b want 0", full0); end
      step();
      dat0 = 8'h3C; wr0 = 1'b1;
      step();
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL ar_hold_busy got %b want 0", busy0); end
      rst = 1'b0;
      step();
      wr0 = 1'b0;
      checks++; if (busy0 !== 1'b1 || tx0 !== 1'b1) begin errors++; $display("FAIL ar_first_write busy=%b tx=%b want 1/1", busy0, tx0); end
      step();
      for (int t = 0; t <= 100; t++) begin
         if (t % 10 == 5) begin
            checks++; if (tx0 !== exp[t/10]) begin errors++; $display("FAIL ar_bit%0d got %b want %b", t/10, tx0, exp[t/10]); end
         end
         if (t == 100) begin
            checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL ar_discard got %b want 0", busy0); end
         end
         if (t < 100) step();
      end
   endtask

   task automatic test_defaults();
      logic [9:0] exp;
      int         first_rise, done;
      exp = {1'b1, 8'hA3, 1'b0};
      first_rise = -1; done = -1;
      dat2 = 8'hA3; wr2 = 1'b1;
      step();
      wr2 = 1'b0;
      step();
      for (int t = 0; t <= 7000; t++) begin
         if (first_rise < 0 && tx2 === 1'b1) first_rise = t;
         if (busy2 === 1'b0) begin
            done = t;
            break;
         end
         for (int k = 0; k < 10; k++) begin
            if (t == 590 * k + 295) begin
               checks++; if (tx2 !== exp[k]) begin errors++; $display("FAIL def_bit%0d got %b want %b", k, tx2, exp[k]); end
            end
         end
         step();
      end
      checks++; if (first_rise < 590 || first_rise > 591) begin errors++; $display("FAIL def_start_len got %0d want 590..591", first_rise); end
      checks++; if (done < 5902 || done > 5904) begin errors++; $display("FAIL def_frame_len got %0d want 5902..5904", done); end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_7e2_parity();
      test_fifo_full();
      test_full_push_pop();
      test_async_reset();
      test_defaults();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
